see_error_monitor: RTL

- Downstream stage of the SEE fault-injection combinational netlist under test (9-bit input vector, 5-bit output).
- Each cycle, accepts one applied input vector together with the faulted netlist outputs and the golden (fault-free) outputs.
- Compares the two output sets, maintains vector, error and per-bit sticky statistics, and buffers mismatch records in a small FIFO for host readout.
- Campaign length is programmable; the block reports done once all vectors have been compared.

---
 rtl/see_mon_pkg.sv | 25 ++
 rtl/see_error_monitor_if.sv | 29 ++
 rtl/see_err_fifo.sv | 65 ++++++
 rtl/see_error_monitor.sv | 109 ++++++++++
 4 files changed

// File: rtl/see_mon_pkg.sv
// Shared types and widths for the SEE error monitor.
package see_mon_pkg;

  localparam int IN_W           = 9;
  localparam int OUT_W          = 5;
  localparam int CNT_W          = 16;
  localparam int DEF_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH,
    DONE
  } state_t;

  // One mismatch record: which vector, what was applied, which outputs differed.
  typedef struct packed {
    logic [CNT_W-1:0] idx;
    logic [IN_W-1:0]  vec;
    logic [OUT_W-1:0] mask;
  } err_rec_t;

  localparam int REC_W = CNT_W + IN_W + OUT_W;

endpackage

// File: rtl/see_error_monitor_if.sv
// Vector-input and record-output streams of the SEE error monitor.
interface see_error_monitor_if;
  import see_mon_pkg::*;

  logic             vec_valid;
  logic             vec_ready;
  logic [IN_W-1:0]  vec_in;
  logic [OUT_W-1:0] dut_out;
  logic [OUT_W-1:0] gold_out;

  logic             rec_valid;
  logic             rec_ready;
  logic [CNT_W-1:0] rec_idx;
  logic [IN_W-1:0]  rec_vec;
  logic [OUT_W-1:0] rec_mask;

  // Stimulus source and host side.
  modport master (
    output vec_valid, vec_in, dut_out, gold_out, rec_ready,
    input  vec_ready, rec_valid, rec_idx, rec_vec, rec_mask
  );

  // Monitor side.
  modport slave (
    input  vec_valid, vec_in, dut_out, gold_out, rec_ready,
    output vec_ready, rec_valid, rec_idx, rec_vec, rec_mask
  );

endinterface

// File: rtl/see_err_fifo.sv
// Small synchronous FIFO of mismatch records. A push while full is accepted
// only when a pop happens in the same cycle; head reads as zero when empty.
module see_err_fifo
  import see_mon_pkg::*;
#(
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     clr,
  input  logic     push,
  input  err_rec_t din,
  input  logic     pop,
  output err_rec_t head,
  output logic     full,
  output logic     empty
);

  localparam int              AW       = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]     FULL_CNT = (AW + 1)'(FIFO_DEPTH);

  err_rec_t        mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic            do_push;
  logic            do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : mem[rd_ptr];

  // Pointer and occupancy bookkeeping; clr empties the FIFO for a new campaign.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Record storage.
  always_ff @(posedge clk) begin
    // NOTE: storage has no reset; occupancy is tracked by count, and head is
    // masked while empty, so stale contents are never visible.
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/see_error_monitor.sv
// Compares faulted and golden netlist outputs per applied vector, keeps
// campaign statistics and queues mismatch records for host readout.
module see_error_monitor
  import see_mon_pkg::*;
#(
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [CNT_W-1:0]    num_vectors,
  see_error_monitor_if.slave  bus,
  output logic [CNT_W-1:0]    vec_count,
  output logic [CNT_W-1:0]    err_count,
  output logic [OUT_W-1:0]    sticky_mask,
  output logic                overflow,
  output logic                busy,
  output logic                done
);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] num_lat;
  logic             start_go;
  logic             xfer;

  logic             stage_valid;
  err_rec_t         stage_rec;
  logic             rec_push;
  logic             rec_pop;
  logic             fifo_full;
  logic             fifo_empty;
  err_rec_t         fifo_head;

  assign start_go      = start && ((state == IDLE) || (state == DONE));
  assign bus.vec_ready = (state == RUN) && (vec_count < num_lat);
  assign xfer          = bus.vec_valid && bus.vec_ready;
  assign busy          = (state == RUN) || (state == FLUSH);
  assign done          = (state == DONE);

  assign rec_push      = stage_valid && (stage_rec.mask != '0);
  assign rec_pop       = bus.rec_valid && bus.rec_ready;
  assign bus.rec_valid = !fifo_empty;
  assign bus.rec_idx   = fifo_head.idx;
  assign bus.rec_vec   = fifo_head.vec;
  assign bus.rec_mask  = fifo_head.mask;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic. A zero-length campaign has already reached its target
  // on the start edge, so it goes straight to FLUSH. FLUSH lasts one cycle:
  // no transfers happen there, so the stage drains on its closing edge.
  always_comb begin
    // NOTE: default first so every path assigns state_nxt and no latch forms.
    state_nxt = state;
    unique case (state)
      IDLE, DONE: if (start) state_nxt = (num_vectors == '0) ? FLUSH : RUN;
      RUN:        if (xfer && ((vec_count + CNT_W'(1)) == num_lat)) state_nxt = FLUSH;
      FLUSH:      state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  // Counters, compare stage and campaign statistics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num_lat     <= '0;
      vec_count   <= '0;
      err_count   <= '0;
      sticky_mask <= '0;
      overflow    <= 1'b0;
      stage_valid <= 1'b0;
      stage_rec   <= '0;
    end else if (start_go) begin
      num_lat     <= num_vectors;
      vec_count   <= '0;
      err_count   <= '0;
      sticky_mask <= '0;
      overflow    <= 1'b0;
      stage_valid <= 1'b0;
    end else begin
      if (xfer) begin
        vec_count <= vec_count + CNT_W'(1);
        stage_rec <= '{idx: vec_count, vec: bus.vec_in, mask: bus.dut_out ^ bus.gold_out};
      end
      stage_valid <= xfer;
      if (stage_valid) sticky_mask <= sticky_mask | stage_rec.mask;
      if (rec_push && (err_count != '1)) err_count <= err_count + CNT_W'(1);
      if (rec_push && fifo_full && !rec_pop) overflow <= 1'b1;
    end
  end

  see_err_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start_go),
    .push  (rec_push),
    .din   (stage_rec),
    .pop   (rec_pop),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule
